// File: rtl/updownstream_scheduler_pkg.sv
// Shared types for the order-processor scheduler.
//   cpu_cmd_t  : CPU command {new_max, client_id, amount}
//   exch_cmd_t : exchange cancellation {client_id, amount}
//   sched_state_t : issue FSM states
//   src_t      : requester identity used by the arbiter
package updownstream_pkg;

  localparam int unsigned CLIENT_ID_W = 5;
  localparam int unsigned CPU_AMT_W   = 32;
  localparam int unsigned EXCH_AMT_W  = 16;

  typedef struct packed {
    logic                   new_max;
    logic [CLIENT_ID_W-1:0] client_id;
    logic [CPU_AMT_W-1:0]   amount;
  } cpu_cmd_t;

  typedef struct packed {
    logic [CLIENT_ID_W-1:0] client_id;
    logic [EXCH_AMT_W-1:0]  amount;
  } exch_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } sched_state_t;

  typedef enum logic {
    SRC_CPU,
    SRC_EXCH
  } src_t;

  // Round-robin choice on a tie: grant whoever did not win last time.
  function automatic src_t rr_pick(input src_t last);
    return (last == SRC_CPU) ? SRC_EXCH : SRC_CPU;
  endfunction

endpackage

// File: rtl/updownstream_scheduler_if.sv
// Request/issue bundle between the request sources, the scheduler and the
// order processor.
//   slave  : scheduler view (takes requests, drives ready/issue/status)
//   master : source/processor view (drives requests, observes the rest)
interface updownstream_scheduler_if;
  import updownstream_pkg::*;

  // CPU request channel
  logic                   cpu_req_valid;
  logic                   cpu_req_ready;
  logic                   cpu_req_new_max;
  logic [CLIENT_ID_W-1:0] cpu_req_client_id;
  logic [CPU_AMT_W-1:0]   cpu_req_amount;

  // Exchange request channel
  logic                   exch_req_valid;
  logic                   exch_req_ready;
  logic [CLIENT_ID_W-1:0] exch_req_client_id;
  logic [EXCH_AMT_W-1:0]  exch_req_amount;

  // Issue to the processor
  logic                   cpu_go;
  logic                   cpu_new_max;
  logic [CLIENT_ID_W-1:0] cpu_client_id;
  logic [CPU_AMT_W-1:0]   cpu_amount;
  logic                   exchange_go;
  logic [CLIENT_ID_W-1:0] exchange_client_id;
  logic [EXCH_AMT_W-1:0]  exchange_amount;

  // Status
  logic                   busy;
  logic [15:0]            cpu_issued_cnt;
  logic [15:0]            exch_issued_cnt;

  modport slave (
    input  cpu_req_valid, cpu_req_new_max, cpu_req_client_id, cpu_req_amount,
    input  exch_req_valid, exch_req_client_id, exch_req_amount,
    output cpu_req_ready, exch_req_ready,
    output cpu_go, cpu_new_max, cpu_client_id, cpu_amount,
    output exchange_go, exchange_client_id, exchange_amount,
    output busy, cpu_issued_cnt, exch_issued_cnt
  );

  modport master (
    output cpu_req_valid, cpu_req_new_max, cpu_req_client_id, cpu_req_amount,
    output exch_req_valid, exch_req_client_id, exch_req_amount,
    input  cpu_req_ready, exch_req_ready,
    input  cpu_go, cpu_new_max, cpu_client_id, cpu_amount,
    input  exchange_go, exchange_client_id, exchange_amount,
    input  busy, cpu_issued_cnt, exch_issued_cnt
  );

endinterface

// File: rtl/updownstream_scheduler_cmd_fifo.sv
// Small synchronous command FIFO with registered full flag.
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write request (ignored while o_full)
//   i_data    : write payload
//   i_pop     : read request (ignored while o_empty); o_data is the head
//   o_data    : current head entry
//   o_full    : registered from next occupancy, so a same-cycle pop never
//               lowers it early; held high during reset
//   o_empty   : occupancy is zero (no bypass from a same-cycle push)
module updownstream_cmd_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic          r_full;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = r_full;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !r_full;
  assign w_pop   = i_pop && !o_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Full resets high so the source sees ready low while reset is applied;
  // it drops at the first clock after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/updownstream_scheduler.sv
// Shares the upstream/downstream order processor between the CPU (new max /
// order amounts) and the exchange (cancellations). Each source is buffered
// in its own FIFO; one command at a time is issued as a go pulse held for
// HOLD_CYCLES, followed by GAP_CYCLES with both go outputs low.
//   clk, rst : clock, asynchronous active-high reset
//   sif      : updownstream_scheduler_if.slave (request channels with
//              ready, issued go/payload outputs, busy, issue counters)
// Build option: EXCH_PRIORITY_EN -- when defined, the exchange wins every
// tie; otherwise ties are resolved round-robin.
module updownstream_scheduler
  import updownstream_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input logic                      clk,
  input logic                      rst,
  updownstream_scheduler_if.slave  sif
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  sched_state_t r_state;
  sched_state_t w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  cpu_cmd_t  w_cpu_in;
  cpu_cmd_t  w_cpu_head;
  exch_cmd_t w_exch_in;
  exch_cmd_t w_exch_head;
  logic      w_cpu_full;
  logic      w_cpu_empty;
  logic      w_exch_full;
  logic      w_exch_empty;
  logic      w_cpu_pop;
  logic      w_exch_pop;

  logic      w_issue;
  src_t      w_grant;
  src_t      w_tie_grant;

  cpu_cmd_t    r_cpu_cmd;
  exch_cmd_t   r_exch_cmd;
  logic        r_cpu_go;
  logic        r_exch_go;
  logic [15:0] r_cpu_issued_cnt;
  logic [15:0] r_exch_issued_cnt;

  // ---------------------------------------------------------------------
  // Request FIFOs
  // ---------------------------------------------------------------------
  assign w_cpu_in  = {sif.cpu_req_new_max, sif.cpu_req_client_id, sif.cpu_req_amount};
  assign w_exch_in = {sif.exch_req_client_id, sif.exch_req_amount};

  updownstream_cmd_fifo #(
    .W     ($bits(cpu_cmd_t)),
    .DEPTH (DEPTH)
  ) u_cpu_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (sif.cpu_req_valid),
    .i_data  (w_cpu_in),
    .i_pop   (w_cpu_pop),
    .o_data  (w_cpu_head),
    .o_full  (w_cpu_full),
    .o_empty (w_cpu_empty)
  );

  updownstream_cmd_fifo #(
    .W     ($bits(exch_cmd_t)),
    .DEPTH (DEPTH)
  ) u_exch_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (sif.exch_req_valid),
    .i_data  (w_exch_in),
    .i_pop   (w_exch_pop),
    .o_data  (w_exch_head),
    .o_full  (w_exch_full),
    .o_empty (w_exch_empty)
  );

  assign sif.cpu_req_ready  = !w_cpu_full;
  assign sif.exch_req_ready = !w_exch_full;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
`ifdef EXCH_PRIORITY_EN
  // Cancellations win every tie; no rotation state is kept.
  assign w_tie_grant = SRC_EXCH;
`else
  src_t r_last_grant;

  // Reset to EXCH so the CPU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= SRC_EXCH;
    end else if (w_issue) begin
      r_last_grant <= w_grant;
    end
  end

  assign w_tie_grant = rr_pick(r_last_grant);
`endif

  always_comb begin
    w_grant = SRC_CPU;
    if (!w_cpu_empty && !w_exch_empty) begin
      w_grant = w_tie_grant;
    end else if (w_exch_empty) begin
      w_grant = SRC_CPU;
    end else begin
      w_grant = SRC_EXCH;
    end
  end

  assign w_cpu_pop  = w_issue && (w_grant == SRC_CPU);
  assign w_exch_pop = w_issue && (w_grant == SRC_EXCH);

  // ---------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_cpu_empty || !w_exch_empty) begin
          w_issue     = 1'b1;
          w_state_nxt = HOLD;
          w_cnt_nxt   = CW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = CW'(GAP_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Issued payload, go strobes and counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpu_go          <= 1'b0;
      r_exch_go         <= 1'b0;
      r_cpu_cmd         <= '0;
      r_exch_cmd        <= '0;
      r_cpu_issued_cnt  <= '0;
      r_exch_issued_cnt <= '0;
    end else begin
      if (w_issue) begin
        r_cpu_go  <= (w_grant == SRC_CPU);
        r_exch_go <= (w_grant == SRC_EXCH);
        // Only the granted side's payload moves; the other holds.
        if (w_grant == SRC_CPU) begin
          r_cpu_cmd        <= w_cpu_head;
          r_cpu_issued_cnt <= r_cpu_issued_cnt + 16'd1;
        end else begin
          r_exch_cmd        <= w_exch_head;
          r_exch_issued_cnt <= r_exch_issued_cnt + 16'd1;
        end
      end else if (r_state == HOLD && r_cnt == '0) begin
        r_cpu_go  <= 1'b0;
        r_exch_go <= 1'b0;
      end
    end
  end

  assign sif.cpu_go             = r_cpu_go;
  assign sif.cpu_new_max        = r_cpu_cmd.new_max;
  assign sif.cpu_client_id      = r_cpu_cmd.client_id;
  assign sif.cpu_amount         = r_cpu_cmd.amount;
  assign sif.exchange_go        = r_exch_go;
  assign sif.exchange_client_id = r_exch_cmd.client_id;
  assign sif.exchange_amount    = r_exch_cmd.amount;
  assign sif.cpu_issued_cnt     = r_cpu_issued_cnt;
  assign sif.exch_issued_cnt    = r_exch_issued_cnt;
  assign sif.busy               = (r_state != IDLE) || !w_cpu_empty || !w_exch_empty;

endmodule

// File: tb/tb_updownstream_scheduler.sv
module tb_updownstream_scheduler;
  import updownstream_pkg::*;

  localparam int HOLD = 4;
  localparam int GAP  = 4;
  localparam int SPACING = HOLD + GAP + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  updownstream_scheduler_if ifc();

  updownstream_scheduler #(
    .DEPTH       (4),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sif (ifc.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    src_t        src;
    logic        nm;
    logic [4:0]  id;
    logic [31:0] amt;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic void add_exp(input src_t s, input logic nm, input logic [4:0] id, input logic [31:0] amt);
    exp_t e;
    e.src = s; e.nm = nm; e.id = id; e.amt = amt;
    exp_q.push_back(e);
  endfunction

  // ---------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------
  logic        prev_cpu, prev_exch;
  int          cpu_len, exch_len;
  int          last_rise;
  int          cpu_rise_cyc, exch_rise_cyc;
  int          cpu_seen;
  logic [15:0] exch_seen;
  logic [37:0] cpu_lat, last_cpu_pl, cur_cpu_pl;
  logic [20:0] exch_lat, last_exch_pl, cur_exch_pl;

  always @(negedge clk) begin
    if (rst) begin
      prev_cpu = 1'b0; prev_exch = 1'b0;
      cpu_len = 0; exch_len = 0; last_rise = -1;
      cpu_seen = 0; exch_seen = '0;
      last_cpu_pl = '0; last_exch_pl = '0;
    end else begin
      cur_cpu_pl  = {ifc.cpu_new_max, ifc.cpu_client_id, ifc.cpu_amount};
      cur_exch_pl = {ifc.exchange_client_id, ifc.exchange_amount};
      check("go_mutex", 64'(ifc.cpu_go & ifc.exchange_go), 64'd0);

      if (ifc.cpu_go && !prev_cpu) begin
        exp_t e;
        if (last_rise >= 0) check("issue_spacing_ok", 64'((cyc - last_rise) >= SPACING), 64'd1);
        last_rise = cyc; cpu_rise_cyc = cyc; cpu_len = 1;
        cpu_seen++;
        check("cpu_issued_cnt", 64'(ifc.cpu_issued_cnt), 64'(cpu_seen));
        check("exch_payload_held", 64'(cur_exch_pl), 64'(last_exch_pl));
        if (exp_q.size() == 0) begin
          check("unexpected_cpu_issue", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("issue_src_cpu", 64'(SRC_CPU), 64'(e.src));
          check("cpu_payload", 64'(cur_cpu_pl), 64'({e.nm, e.id, e.amt}));
        end
        cpu_lat = cur_cpu_pl; last_cpu_pl = cur_cpu_pl;
      end else if (ifc.cpu_go) begin
        cpu_len++;
        check("cpu_payload_stable", 64'(cur_cpu_pl), 64'(cpu_lat));
      end else if (prev_cpu) begin
        check("cpu_hold_len", 64'(cpu_len), 64'(HOLD));
      end

      if (ifc.exchange_go && !prev_exch) begin
        exp_t e;
        if (last_rise >= 0) check("issue_spacing_ok", 64'((cyc - last_rise) >= SPACING), 64'd1);
        last_rise = cyc; exch_rise_cyc = cyc; exch_len = 1;
        exch_seen = exch_seen + 16'd1;
        check("exch_issued_cnt", 64'(ifc.exch_issued_cnt), 64'(exch_seen));
        check("cpu_payload_held", 64'(cur_cpu_pl), 64'(last_cpu_pl));
        if (exp_q.size() == 0) begin
          check("unexpected_exch_issue", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("issue_src_exch", 64'(SRC_EXCH), 64'(e.src));
          check("exch_payload", 64'(cur_exch_pl), 64'({e.id, e.amt[15:0]}));
        end
        exch_lat = cur_exch_pl; last_exch_pl = cur_exch_pl;
      end else if (ifc.exchange_go) begin
        exch_len++;
        check("exch_payload_stable", 64'(cur_exch_pl), 64'(exch_lat));
      end else if (prev_exch) begin
        check("exch_hold_len", 64'(exch_len), 64'(HOLD));
      end

      prev_cpu  = ifc.cpu_go;
      prev_exch = ifc.exchange_go;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic push_cpu(input logic nm, input logic [4:0] id, input logic [31:0] amt, output int pcyc);
    int g = 0;
    ifc.cpu_req_valid = 1'b1; ifc.cpu_req_new_max = nm;
    ifc.cpu_req_client_id = id; ifc.cpu_req_amount = amt;
    while (!ifc.cpu_req_ready && g < 200) begin @(posedge clk); #1; g++; end
    if (!ifc.cpu_req_ready) check("cpu_push_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    pcyc = cyc;
    ifc.cpu_req_valid = 1'b0;
  endtask

  task automatic push_exch(input logic [4:0] id, input logic [15:0] amt, output int pcyc);
    int g = 0;
    ifc.exch_req_valid = 1'b1; ifc.exch_req_client_id = id; ifc.exch_req_amount = amt;
    while (!ifc.exch_req_ready && g < 200) begin @(posedge clk); #1; g++; end
    if (!ifc.exch_req_ready) check("exch_push_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    pcyc = cyc;
    ifc.exch_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    do begin @(negedge clk); #1; g++; end
    while ((ifc.busy || exp_q.size() != 0 || ifc.cpu_go || ifc.exchange_go) && g < 2000);
    check({tag, "_idle_timeout"}, 64'(g >= 2000), 64'd0);
  endtask

  task automatic wait_cpu(input int n);
    int g = 0;
    while (cpu_seen < n && g < 300) begin @(negedge clk); #1; g++; end
    check("wait_cpu_issue_timeout", 64'(cpu_seen < n), 64'd0);
  endtask

  task automatic wait_exch(input int n);
    int g = 0;
    while (int'(exch_seen) < n && g < 300) begin @(negedge clk); #1; g++; end
    check("wait_exch_issue_timeout", 64'(int'(exch_seen) < n), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------
  initial begin
    int pc, pc_f, pce;
    rst = 1'b1;
    ifc.cpu_req_valid = 1'b0; ifc.cpu_req_new_max = 1'b0;
    ifc.cpu_req_client_id = '0; ifc.cpu_req_amount = '0;
    ifc.exch_req_valid = 1'b0; ifc.exch_req_client_id = '0; ifc.exch_req_amount = '0;

    // Reset state
    #1;
    check("rst_cpu_go", 64'(ifc.cpu_go), 64'd0);
    check("rst_exch_go", 64'(ifc.exchange_go), 64'd0);
    check("rst_busy", 64'(ifc.busy), 64'd0);
    check("rst_cpu_cnt", 64'(ifc.cpu_issued_cnt), 64'd0);
    check("rst_exch_cnt", 64'(ifc.exch_issued_cnt), 64'd0);
    check("rst_cpu_amount", 64'(ifc.cpu_amount), 64'd0);
    do_reset();
    check("post_rst_cpu_ready", 64'(ifc.cpu_req_ready), 64'd1);
    check("post_rst_exch_ready", 64'(ifc.exch_req_ready), 64'd1);

    // T1: single CPU request, one-cycle latency
    add_exp(SRC_CPU, 1'b1, 5'd3, 32'd1000);
    push_cpu(1'b1, 5'd3, 32'd1000, pc);
    wait_cpu(1);
    check("t1_latency", 64'(cpu_rise_cyc), 64'(pc + 1));
    wait_idle("t1");
    check("t1_cpu_cnt", 64'(ifc.cpu_issued_cnt), 64'd1);
    check("t1_exch_cnt", 64'(ifc.exch_issued_cnt), 64'd0);

    // T2: simultaneous push from a fresh reset
    do_reset();
`ifdef EXCH_PRIORITY_EN
    add_exp(SRC_EXCH, 1'b0, 5'd7, 32'd50);
    add_exp(SRC_CPU, 1'b0, 5'd1, 32'd2000);
`else
    add_exp(SRC_CPU, 1'b0, 5'd1, 32'd2000);
    add_exp(SRC_EXCH, 1'b0, 5'd7, 32'd50);
`endif
    fork
      begin int p1; push_cpu(1'b0, 5'd1, 32'd2000, p1); end
      begin int p2; push_exch(5'd7, 16'd50, p2); end
    join
    wait_idle("t2");
`ifdef EXCH_PRIORITY_EN
    check("t2_prio_gap", 64'(cpu_rise_cyc - exch_rise_cyc), 64'(SPACING));
`else
    check("t2_rr_gap", 64'(exch_rise_cyc - cpu_rise_cyc), 64'(SPACING));
`endif

    // T3: CPU FIFO fills while an exchange issue is in progress
    add_exp(SRC_EXCH, 1'b0, 5'd2, 32'd11);
    push_exch(5'd2, 16'd11, pce);
    for (int i = 0; i < 4; i++) begin
      add_exp(SRC_CPU, 1'(i), 5'(i + 8), 32'(3000 + i));
      push_cpu(1'(i), 5'(i + 8), 32'(3000 + i), pc);
    end
    check("t3_ready_low_when_full", 64'(ifc.cpu_req_ready), 64'd0);
    add_exp(SRC_CPU, 1'b1, 5'd31, 32'hDEADBEEF);
    push_cpu(1'b1, 5'd31, 32'hDEADBEEF, pc_f);
    check("t3_fifth_after_pop", 64'(pc_f), 64'(cpu_rise_cyc + 1));
    wait_idle("t3");

    // T4: asynchronous reset during an exchange HOLD
    do_reset();
    add_exp(SRC_EXCH, 1'b0, 5'd9, 32'd77);
    push_exch(5'd9, 16'd77, pce);
    push_cpu(1'b0, 5'd12, 32'd555, pc);
    wait_exch(1);
    check("t4_in_hold", 64'(ifc.exchange_go), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t4_async_exch_go", 64'(ifc.exchange_go), 64'd0);
    check("t4_busy", 64'(ifc.busy), 64'd0);
    check("t4_exch_cnt", 64'(ifc.exch_issued_cnt), 64'd0);
    check("t4_cpu_cnt", 64'(ifc.cpu_issued_cnt), 64'd0);
    do_reset();
    add_exp(SRC_CPU, 1'b0, 5'd4, 32'd123);
    push_cpu(1'b0, 5'd4, 32'd123, pc);
    wait_idle("t4");
    check("t4_after_cpu_cnt", 64'(ifc.cpu_issued_cnt), 64'd1);

    // T5: continuous requests on both sources, 20 issues
    do_reset();
`ifdef EXCH_PRIORITY_EN
    for (int k = 0; k < 10; k++) add_exp(SRC_EXCH, 1'b0, 5'(k + 20), 32'(200 + k));
    for (int k = 0; k < 10; k++) add_exp(SRC_CPU, 1'(k), 5'(k + 10), 32'(100 + k));
`else
    for (int k = 0; k < 10; k++) begin
      add_exp(SRC_CPU, 1'(k), 5'(k + 10), 32'(100 + k));
      add_exp(SRC_EXCH, 1'b0, 5'(k + 20), 32'(200 + k));
    end
`endif
    fork
      begin
        int p1;
        for (int i = 0; i < 10; i++) push_cpu(1'(i), 5'(i + 10), 32'(100 + i), p1);
      end
      begin
        int p2;
        for (int j = 0; j < 10; j++) push_exch(5'(j + 20), 16'(200 + j), p2);
      end
    join
    wait_idle("t5");
    check("t5_cpu_cnt", 64'(ifc.cpu_issued_cnt), 64'd10);
    check("t5_exch_cnt", 64'(ifc.exch_issued_cnt), 64'd10);

    // T6: exchange counter wraps
    force dut.r_exch_issued_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_exch_issued_cnt;
    exch_seen = 16'hFFFF;
    #1;
    check("t6_preload", 64'(ifc.exch_issued_cnt), 64'hFFFF);
    add_exp(SRC_EXCH, 1'b0, 5'd5, 32'd9);
    push_exch(5'd5, 16'd9, pce);
    wait_idle("t6");
    check("t6_wrap", 64'(ifc.exch_issued_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
